data_mem_responder: RTL and testbench

//   Responder side of the multicycle CPU's data-memory port: services load/store requests

---
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the multicycle CPU: req/ack handshake with a fixed number of
// wait states in front of a word-organised storage array.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be within 0..15");
  end
  if (DEPTH_WORDS < 2) begin : g_bad_depth
    $error("DEPTH_WORDS must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic        do_access;
  logic        mem_wr;

  always_comb begin
    // A zero-wait access fires on the accepting edge, so it must use the live inputs.
    acc_we    = (state_q == StIdle) ? we    : we_q;
    acc_addr  = (state_q == StIdle) ? addr  : addr_q;
    acc_wdata = (state_q == StIdle) ? wdata : wdata_q;
    acc_err   = (acc_addr[1:0] != 2'b00) ||
                ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));

    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    do_access = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d   = StResp;
            do_access = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = StResp;
          do_access = 1'b1;
          cnt_d     = 4'd0;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    mem_wr  = do_access && acc_we && !acc_err;
    ack_d   = do_access;
    err_d   = do_access && acc_err;
    rdata_d = (do_access && !acc_we && !acc_err) ? mem[acc_addr[AW+1:2]] : 32'd0;
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is deliberately not cleared by reset; reset only suppresses a pending write.
  always_ff @(posedge CLK) begin
    if (RST && mem_wr) begin
      mem[acc_addr[AW+1:2]] <= acc_wdata;
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance for the main table and
// sequences, plus a WAIT_CYCLES=0 instance for zero-wait latency.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        ack, err, busy;
  logic [31:0] rdata;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RST(RST), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction; ack is expected at the negedge following the edge E0+w.
  task automatic txn(input bit zero, input vec_t v);
    logic        early;
    logic        a, e, b;
    logic [31:0] r;
    int          w;
    w = zero ? 0 : 2;
    @(negedge CLK);
    if (zero) begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end else begin
      req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
    end
    @(posedge CLK);
    early = 1'b0;
    for (int k = 0; k <= w; k++) begin
      @(negedge CLK);
      a = zero ? ack0 : ack;
      b = zero ? busy0 : busy;
      if (k < w && (a !== 1'b0 || b !== 1'b1)) early = 1'b1;
      // Initiator scrambles inputs during the wait to show the latched copies are used.
      if (k < w && !zero) begin
        req = 1'b0; we = ~v.we; addr = 32'h3; wdata = 32'hFFFF_FFFF;
      end
    end
    a = zero ? ack0 : ack;
    e = zero ? err0 : err;
    r = zero ? rdata0 : rdata;
    chk("no_early_ack", {31'd0, early}, 32'd0);
    chk("ack_latency", {31'd0, a}, 32'd1);
    chk("err", {31'd0, e}, {31'd0, v.exp_err});
    chk("rdata", r, v.exp_rdata);
    if (zero) req0 = 1'b0; else req = 1'b0;
    @(negedge CLK);
    a = zero ? ack0 : ack;
    b = zero ? busy0 : busy;
    r = zero ? rdata0 : rdata;
    chk("ack_one_cycle", {30'd0, a, b}, 32'd0);
    chk("rdata_cleared", r, 32'd0);
  endtask

  vec_t tbl [12];
  vec_t seq [6];
  vec_t v;
  int   idx, last_cyc, busy_low, ack_cnt;
  bit   done;

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0};
    tbl[3]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
    tbl[5]  = '{1'b1, 32'h0000_0100, 32'h1111_1111, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hCAFE_F00D};
    tbl[7]  = '{1'b1, 32'h0000_0011, 32'h5555_5555, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[9]  = '{1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hA5A5_A5A5};

    seq[0] = '{1'b1, 32'h0, 32'h0101_0101, 1'b0, 32'h0};
    seq[1] = '{1'b0, 32'h0, 32'h0,         1'b0, 32'h0101_0101};
    seq[2] = '{1'b1, 32'h4, 32'h0202_0202, 1'b0, 32'h0};
    seq[3] = '{1'b0, 32'h4, 32'h0,         1'b0, 32'h0202_0202};
    seq[4] = '{1'b1, 32'h0, 32'h0303_0303, 1'b0, 32'h0};
    seq[5] = '{1'b0, 32'h0, 32'h0,         1'b0, 32'h0303_0303};

    // Reset and idle
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    chk("reset_outs", {ack, err, busy, 29'd0}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ack !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0) ack_cnt++;
    end
    chk("idle_no_ack", ack_cnt, 0);

    for (int i = 0; i < 12; i++) txn(1'b0, tbl[i]);

    // req held high, alternating store/load
    @(negedge CLK);
    req = 1'b1; we = seq[0].we; addr = seq[0].addr; wdata = seq[0].wdata;
    idx = 0; last_cyc = 0; busy_low = 0; done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge CLK);
      if (ack === 1'b1) begin
        chk("b2b_rdata", rdata, seq[idx].exp_rdata);
        chk("b2b_err", {31'd0, err}, 32'd0);
        if (idx > 0) chk("b2b_period", cyc - last_cyc, 4);
        last_cyc = cyc;
        idx++;
        if (idx == 6) begin
          done = 1'b1;
          req = 1'b0;
        end else begin
          we = seq[idx].we; addr = seq[idx].addr; wdata = seq[idx].wdata;
        end
      end else if (busy === 1'b0) begin
        busy_low++;
      end
    end
    chk("b2b_count", idx, 6);
    chk("b2b_busy_low", busy_low, 5);
    @(negedge CLK);

    // Reset during WAIT aborts the store
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; req = 1'b0;
    @(negedge CLK);
    chk("abort_outs", {30'd0, ack, busy}, 32'd0);
    RST = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ack !== 1'b0 || busy !== 1'b0) ack_cnt++;
    end
    chk("abort_no_ack", ack_cnt, 0);
    v = '{1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5_A5A5};
    txn(1'b0, v);

    // Zero-wait instance
    v = '{1'b1, 32'h8, 32'h0BAD_C0DE, 1'b0, 32'h0};
    txn(1'b1, v);
    v = '{1'b0, 32'h8, 32'h0, 1'b0, 32'h0BAD_C0DE};
    txn(1'b1, v);
    v = '{1'b0, 32'h102, 32'h0, 1'b1, 32'h0};
    txn(1'b1, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
